// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed single-port data RAM with sized loads/stores and a post-reset clear engine
// Ports: clk_i/reset_i (async active-high); req_valid_i/req_ready_o handshake;
//   write_en_i, size_i (00 b, 01 h, 10 w), sign_ext_i, addr_i, write_data_i request fields;
//   read_data_o/read_valid_o registered load result; fault_o one-cycle pulse for a rejected access.
module data_mem_sized #(
  parameter int SIZE           = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        write_en_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        read_valid_o,
  output logic        fault_o
);
  localparam int AW    = $clog2(SIZE);
  localparam int IW    = AW - 2;
  localparam int WORDS = SIZE / 4;
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] clr_idx_q, clr_idx_d, idx;
  logic [31:0] mem [WORDS];
  logic [31:0] read_data_q, read_data_d, wdata, word, shifted, load_val;
  logic        read_valid_q, read_valid_d, fault_q, fault_d, accept, bad, do_load, do_store;
  logic [1:0]  lane;
  logic [3:0]  be;
  assign idx      = addr_i[AW-1:2];
  assign lane     = addr_i[1:0];
  assign accept   = req_valid_i && state_q == S_READY;
  assign bad      = size_i == 2'b11 || (size_i == 2'b01 && lane[0]) ||
                    (size_i == 2'b10 && lane != 2'b00) || |addr_i[31:AW];
  assign do_store = accept && !bad && write_en_i;
  assign do_load  = accept && !bad && !write_en_i;
  // Sub-word store data is replicated across lanes so the byte enables alone pick the target.
  assign wdata    = size_i == 2'b00 ? {4{write_data_i[7:0]}} :
                    size_i == 2'b01 ? {2{write_data_i[15:0]}} : write_data_i;
  assign be       = size_i == 2'b00 ? 4'b0001 << lane :
                    size_i == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
  assign word     = mem[idx];
  assign shifted  = word >> {lane, 3'b000};
  assign load_val = size_i == 2'b00 ? {{24{sign_ext_i & shifted[7]}}, shifted[7:0]} :
                    size_i == 2'b01 ? {{16{sign_ext_i & shifted[15]}}, shifted[15:0]} : word;
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + IW'(1);
      state_d   = clr_idx_q == IW'(WORDS - 1) ? S_READY : S_CLEAR;
    end
    read_data_d  = do_load ? load_val : read_data_q;
    read_valid_d = do_load;
    fault_d      = accept && bad;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_idx_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR)
      mem[clr_idx_q] <= '0;
    else if (do_store)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  end
  assign req_ready_o  = state_q == S_READY;
  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;
  assign fault_o      = fault_q;
endmodule

// File: tb/tb_data_mem_sized.sv
// tb_data_mem_sized: directed plus random checks of data_mem_sized against a byte-array reference model
module tb_data_mem_sized;
  localparam int SIZE = 4096;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, write_en = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, write_data = '0;
  logic        req_ready, read_valid, fault, s_ready, s_rv, s_fault;
  logic [31:0] read_data, s_rd;
  logic [7:0]  ref_mem [SIZE];
  logic [31:0] rd_m = '0;
  int          ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  data_mem_sized #(.SIZE(SIZE), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .write_en_i(write_en), .size_i(size), .sign_ext_i(sign_ext), .addr_i(addr),
    .write_data_i(write_data), .read_data_o(read_data), .read_valid_o(read_valid), .fault_o(fault));

  data_mem_sized #(.SIZE(64), .CLEAR_ON_RESET(1'b0)) u_noclr (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(s_ready),
    .write_en_i(write_en), .size_i(size), .sign_ext_i(sign_ext), .addr_i(addr),
    .write_data_i(write_data), .read_data_o(s_rd), .read_valid_o(s_rv), .fault_o(s_fault));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < SIZE; i++) ref_mem[i] = 8'h00;
    rd_m = '0;
  endtask

  // Counts negedge samples with req_ready low; expects SIZE/4 and no pulses meanwhile.
  task automatic wait_clear(input string tag);
    int n = 0;
    logic pulse = 1'b0;
    while (!req_ready && n < 5000) begin
      pulse = pulse | read_valid | fault;
      @(negedge clk);
      n++;
    end
    chk({tag, " clear cycles"}, 32'(n), 32'(SIZE / 4));
    chk({tag, " clear pulses"}, {31'd0, pulse}, 32'd0);
  endtask

  // One request in one cycle; the model decides fault/load/store from the access rules.
  task automatic op(input logic we, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic f;
    int nb;
    logic [31:0] v;
    req_valid = 1'b1; write_en = we; size = sz; sign_ext = sx; addr = a; write_data = wd;
    f  = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= SIZE;
    nb = sz == 2'd3 ? 0 : 1 << sz;
    if (!f && we)
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
    if (!f && !we) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rd_m = v;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " read_valid"}, {31'd0, read_valid}, {31'd0, !f && !we});
    chk({tag, " fault"}, {31'd0, fault}, {31'd0, f});
    chk({tag, " read_data"}, read_data, rd_m);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    zero_model();
    repeat (3) @(negedge clk);
    chk("reset ready", {31'd0, req_ready}, 32'd0);
    chk("reset read_valid", {31'd0, read_valid}, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset read_data", read_data, 32'd0);
    req_valid = 1'b1; write_en = 1'b0; size = 2'd2; addr = 32'hFFC;
    reset = 1'b0;
    chk("noclr ready", {31'd0, s_ready}, 32'd1);
    wait_clear("first");
    op(1'b0, 2'd2, 1'b0, 32'hFFC, '0, "load top");
    op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "store word");
    for (int i = 0; i < 4; i++) op(1'b0, 2'd0, 1'b0, 32'h10 + 32'(i), '0, "load byte");
    op(1'b0, 2'd0, 1'b1, 32'h13, '0, "load byte sx");
    op(1'b1, 2'd0, 1'b0, 32'h12, 32'h55, "store byte");
    op(1'b0, 2'd2, 1'b0, 32'h10, '0, "load merged");
    op(1'b0, 2'd1, 1'b1, 32'h12, '0, "load half sx");
    op(1'b0, 2'd1, 1'b0, 32'h12, '0, "load half zx");
    op(1'b0, 2'd1, 1'b0, 32'h11, '0, "half misaligned");
    op(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, "word store misaligned");
    op(1'b0, 2'd3, 1'b0, 32'h10, '0, "illegal size");
    op(1'b0, 2'd0, 1'b0, SIZE, '0, "out of range");
    op(1'b0, 2'd2, 1'b0, 32'h10, '0, "after faults");
    op(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, "raw store");
    op(1'b0, 2'd2, 1'b0, 32'h20, '0, "raw load");
    op(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000A5A5, "raw half store");
    op(1'b0, 2'd1, 1'b1, 32'h22, '0, "raw half load");
    repeat (400) begin
      a = $urandom_range(0, 9) == 0 ? SIZE - 8 + $urandom_range(0, 15) : $urandom_range(0, 63);
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, "random");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    zero_model();
    req_valid = 1'b1; write_en = 1'b1; size = 2'd2; addr = 32'h10; write_data = 32'hFFFFFFFF;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midclear ready", {31'd0, req_ready}, 32'd0);
    chk("midclear read_data", read_data, 32'd0);
    reset = 1'b0;
    wait_clear("restart");
    op(1'b0, 2'd2, 1'b0, 32'h10, '0, "cleared word");
    op(1'b0, 2'd2, 1'b0, 32'h20, '0, "cleared raw word");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
